cw_ramp_gen: RTL and testbench

CW_RAMP_GEN -- requirements
Module: cw_ramp_gen

---
 rtl/cw_pkg.sv | 13 +
 rtl/cw_ms_timer.sv | 30 +++
 rtl/cw_ramp_gen.sv | 138 +++++++++++++
 tb/tb_cw_ramp_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cw_pkg.sv
// cw_pkg: shared state encoding and timing defaults for the CW ramp generator
package cw_pkg;
  localparam int CW_CLK_PER_MS = 12288;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY_ON,
    ST_RAMP_UP,
    ST_HOLD,
    ST_DELAY_OFF,
    ST_RAMP_DOWN,
    ST_HANG
  } cw_state_e;
endpackage

// File: rtl/cw_ms_timer.sv
// cw_ms_timer: millisecond prescaler plus ms down-counter; o_done flags expiry of an N ms interval
module cw_ms_timer #(
  parameter int CLK_PER_MS = cw_pkg::CW_CLK_PER_MS
) (
  input  logic       aclk,
  input  logic       resetn,
  input  logic       i_load,
  input  logic [9:0] i_n,
  output logic       o_done
);
  localparam int PW = $clog2(CLK_PER_MS + 1);
  logic [PW-1:0] r_pre;
  logic [9:0]    r_ms;
  // load starts an N ms interval; the counters stop at zero so done stays asserted until reloaded
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (i_load) begin
      r_pre <= PW'(CLK_PER_MS - 1);
      r_ms  <= i_n - 10'd1;
    end else if (r_pre != '0) begin
      r_pre <= r_pre - 1'b1;
    end else if (r_ms != '0) begin
      r_pre <= PW'(CLK_PER_MS - 1);
      r_ms  <= r_ms - 10'd1;
    end
  end
  assign o_done = (r_pre == '0) && (r_ms == '0);
endmodule

// File: rtl/cw_ramp_gen.sv
// cw_ramp_gen: CW keying envelope generator walking a ramp ROM up and down with PTT sequencing
module cw_ramp_gen
  import cw_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int CLK_PER_MS = CW_CLK_PER_MS,
  parameter int IS_AUDIO   = 1
) (
  input  logic                aclk,
  input  logic                resetn,
  input  logic                key_down,
  input  logic                keyer_enable,
  input  logic [7:0]          delay_time,
  input  logic [9:0]          hang_time,
  input  logic [ADDR_W-1:0]   ramp_last,
  input  logic [2:0]          ramp_step,
  output logic                CW_PTT,
  output logic                ramp_busy,
  output logic [2*DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                bram_rst,
  output logic [ADDR_W-1:0]   bram_addr,
  input  logic [DATA_W-1:0]   bram_data
);
  cw_state_e         r_state;
  cw_state_e         w_nxt;
  logic              r_ptt;
  logic              r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_delay;
  logic [9:0]        r_hang;
  logic [ADDR_W-1:0] r_last;
  logic [2:0]        r_step;
  logic              w_active;
  logic              w_load;
  logic [9:0]        w_n;
  logic              w_done;
  logic [ADDR_W:0]   w_step;
  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W-1:0] w_up;
  logic [ADDR_W-1:0] w_down;

  assign w_active = key_down & keyer_enable;
  assign w_step   = (ADDR_W+1)'(r_step == 3'd0 ? 3'd1 : r_step);
  assign w_sum    = {1'b0, r_addr} + w_step;
  assign w_up     = (w_sum > {1'b0, r_last}) ? r_last : w_sum[ADDR_W-1:0];
  assign w_down   = ({1'b0, r_addr} > w_step) ? r_addr - w_step[ADDR_W-1:0] : '0;

  cw_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_timer (
    .aclk   (aclk),
    .resetn (resetn),
    .i_load (w_load),
    .i_n    (w_n),
    .o_done (w_done)
  );

  // next-state decode; the timer is loaded on the transition into each timed state
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_n    = '0;
    case (r_state)
      ST_IDLE, ST_HANG: begin
        if (w_active) begin
          w_nxt  = (delay_time != 8'd0) ? ST_DELAY_ON : ST_RAMP_UP;
          w_load = delay_time != 8'd0;
          w_n    = {2'b00, delay_time};
        end else if (r_state == ST_HANG && w_done) begin
          w_nxt = ST_IDLE;
        end
      end
      ST_DELAY_ON:
        w_nxt = !keyer_enable ? ST_IDLE : w_done ? ST_RAMP_UP : ST_DELAY_ON;
      ST_RAMP_UP:
        w_nxt = !keyer_enable ? ST_RAMP_DOWN : (r_addr == r_last) ? ST_HOLD : ST_RAMP_UP;
      ST_HOLD: begin
        if (!keyer_enable) begin
          w_nxt = ST_RAMP_DOWN;
        end else if (!key_down) begin
          w_nxt  = (r_delay != 8'd0) ? ST_DELAY_OFF : ST_RAMP_DOWN;
          w_load = r_delay != 8'd0;
          w_n    = {2'b00, r_delay};
        end
      end
      ST_DELAY_OFF:
        w_nxt = !keyer_enable ? ST_RAMP_DOWN : key_down ? ST_HOLD : w_done ? ST_RAMP_DOWN : ST_DELAY_OFF;
      ST_RAMP_DOWN: begin
        if (w_active) begin
          w_nxt = ST_RAMP_UP;
        end else if (r_addr == '0) begin
          w_nxt  = (r_hang != 10'd0) ? ST_HANG : ST_IDLE;
          w_load = r_hang != 10'd0;
          w_n    = r_hang;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // state, registered outputs, ramp address and configuration latched at each element start
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_ptt   <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_delay <= '0;
      r_hang  <= '0;
      r_last  <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_nxt;
      r_ptt   <= w_nxt != ST_IDLE;
      r_busy  <= w_nxt inside {ST_DELAY_ON, ST_RAMP_UP, ST_HOLD, ST_DELAY_OFF, ST_RAMP_DOWN};
      if ((r_state == ST_IDLE || r_state == ST_HANG) && w_active) begin
        r_delay <= delay_time;
        r_hang  <= hang_time;
        r_last  <= ramp_last;
        r_step  <= ramp_step;
      end
      if (w_nxt == ST_IDLE)
        r_addr <= '0;
      else if (m_axis_tready && r_state == ST_RAMP_UP && w_nxt == ST_RAMP_UP)
        r_addr <= w_up;
      else if (m_axis_tready && r_state == ST_RAMP_DOWN && w_nxt == ST_RAMP_DOWN)
        r_addr <= w_down;
    end
  end

  assign CW_PTT        = r_ptt;
  assign ramp_busy     = r_busy;
  assign bram_addr     = r_addr;
  assign bram_rst      = ~resetn;
  assign m_axis_tvalid = resetn;
  assign m_axis_tdata  = {(IS_AUDIO != 0) ? bram_data : {DATA_W{1'b0}}, bram_data};
endmodule

// File: tb/tb_cw_ramp_gen.sv
// tb_cw_ramp_gen: directed checks of the CW ramp generator with a 16-cycle millisecond
module tb_cw_ramp_gen;
  import cw_pkg::*;
  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        key_down = 1'b0;
  logic        keyer_enable = 1'b1;
  logic [7:0]  delay_time = 8'd2;
  logic [9:0]  hang_time = 10'd0;
  logic [9:0]  ramp_last = 10'd239;
  logic [2:0]  ramp_step = 3'd1;
  logic        tready = 1'b1;
  logic [15:0] bram_data = '0;
  logic        ptt, busy, tvalid, brst;
  logic [31:0] tdata;
  logic [9:0]  addr;
  logic        ptt0, busy0, tvalid0, brst0;
  logic [31:0] tdata0;
  logic [9:0]  addr0;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit tr_mode = 0;
  bit ptt_watch = 0;

  cw_ramp_gen #(.CLK_PER_MS(16), .IS_AUDIO(1)) dut (
    .aclk(aclk), .resetn(resetn), .key_down(key_down), .keyer_enable(keyer_enable),
    .delay_time(delay_time), .hang_time(hang_time), .ramp_last(ramp_last), .ramp_step(ramp_step),
    .CW_PTT(ptt), .ramp_busy(busy), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .bram_rst(brst), .bram_addr(addr), .bram_data(bram_data)
  );

  cw_ramp_gen #(.CLK_PER_MS(16), .IS_AUDIO(0)) dut0 (
    .aclk(aclk), .resetn(resetn), .key_down(key_down), .keyer_enable(keyer_enable),
    .delay_time(delay_time), .hang_time(hang_time), .ramp_last(ramp_last), .ramp_step(ramp_step),
    .CW_PTT(ptt0), .ramp_busy(busy0), .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0),
    .m_axis_tready(tready), .bram_rst(brst0), .bram_addr(addr0), .bram_data(bram_data)
  );

  always #5 aclk = ~aclk;

  function automatic logic [15:0] rom(input logic [9:0] a);
    return 16'h1000 + {6'd0, a} * 16'd3;
  endfunction

  always @(posedge aclk) bram_data <= rom(addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
    if (tr_mode) tready = (cyc % 4 == 0);
    chk("audio0_upper", 32'(tdata0[31:16]), 32'd0);
    if (ptt_watch) chk("ptt_continuous", 32'(ptt), 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input string tag, input cw_state_e s, input int budget);
    int n = 0;
    while (dut.r_state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(dut.r_state), 32'(s));
  endtask

  task automatic wait_addr(input string tag, input logic [9:0] a, input int budget);
    int n = 0;
    while (addr !== a && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(addr), 32'(a));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] prev;
    logic [9:0] exp_a;
    logic       t_before;
    int         nchg;
    // reset state
    #2;
    chk("rst_ptt", 32'(ptt), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_bram_rst", 32'(brst), 32'd1);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    ticks(2);
    resetn = 1'b1;
    tick();
    chk("run_tvalid", 32'(tvalid), 32'd1);
    chk("run_bram_rst", 32'(brst), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    // delay 2 ms, step 1: key in cycle 0
    key_down = 1'b1;
    tick();
    chk("a_ptt_c1", 32'(ptt), 32'd1);
    chk("a_state_c1", 32'(dut.r_state), 32'(ST_DELAY_ON));
    chk("a_busy_c1", 32'(busy), 32'd1);
    ticks(31);
    chk("a_state_c32", 32'(dut.r_state), 32'(ST_DELAY_ON));
    chk("a_addr_c32", 32'(addr), 32'd0);
    tick();
    chk("a_state_c33", 32'(dut.r_state), 32'(ST_RAMP_UP));
    chk("a_addr_c33", 32'(addr), 32'd0);
    tick();
    chk("a_addr_c34", 32'(addr), 32'd1);
    ticks(238);
    chk("a_addr_c272", 32'(addr), 32'd239);
    chk("a_state_c272", 32'(dut.r_state), 32'(ST_RAMP_UP));
    tick();
    chk("a_state_c273", 32'(dut.r_state), 32'(ST_HOLD));
    delay_time = 8'd0;
    ticks(127);
    chk("a_hold_addr", 32'(addr), 32'd239);
    chk("a_tdata_audio", tdata, {rom(10'd239), rom(10'd239)});
    chk("a_tdata_mono", tdata0, {16'd0, rom(10'd239)});
    key_down = 1'b0;
    tick();
    chk("a_delay_off", 32'(dut.r_state), 32'(ST_DELAY_OFF));
    chk("a_delay_off_ptt", 32'(ptt), 32'd1);
    key_down = 1'b1;
    tick();
    chk("a_back_hold", 32'(dut.r_state), 32'(ST_HOLD));
    key_down = 1'b0;
    tick();
    chk("a_latched_delay", 32'(dut.r_state), 32'(ST_DELAY_OFF));
    ticks(31);
    chk("a_delay_off_end", 32'(dut.r_state), 32'(ST_DELAY_OFF));
    tick();
    chk("a_ramp_down", 32'(dut.r_state), 32'(ST_RAMP_DOWN));
    chk("a_rd_addr0", 32'(addr), 32'd239);
    tick();
    chk("a_rd_addr1", 32'(addr), 32'd238);
    wait_state("a_idle", ST_IDLE, 300);
    chk("a_idle_ptt", 32'(ptt), 32'd0);
    chk("a_idle_addr", 32'(addr), 32'd0);
    // step 4 with tready every 4th cycle
    ramp_step = 3'd4;
    tr_mode = 1;
    key_down = 1'b1;
    prev = '0;
    nchg = 0;
    for (int i = 0; i < 400; i++) begin
      t_before = tready;
      tick();
      if (addr !== prev) begin
        exp_a = (prev > 10'd235) ? 10'd239 : prev + 10'd4;
        chk("b_seq", 32'(addr), 32'(exp_a));
        chk("b_tready_gate", 32'(t_before), 32'd1);
        prev = addr;
        nchg++;
      end
    end
    chk("b_nsteps", 32'(nchg), 32'd60);
    chk("b_saturate", 32'(addr), 32'd239);
    chk("b_hold", 32'(dut.r_state), 32'(ST_HOLD));
    tr_mode = 0;
    tready = 1'b1;
    key_down = 1'b0;
    wait_state("b_idle", ST_IDLE, 200);
    // re-key during ramp down at address 100
    ramp_step = 3'd1;
    key_down = 1'b1;
    wait_state("c_hold", ST_HOLD, 300);
    key_down = 1'b0;
    wait_addr("c_addr100", 10'd100, 300);
    chk("c_rd_state", 32'(dut.r_state), 32'(ST_RAMP_DOWN));
    key_down = 1'b1;
    ptt_watch = 1;
    tick();
    chk("c_rekey_state", 32'(dut.r_state), 32'(ST_RAMP_UP));
    chk("c_rekey_addr", 32'(addr), 32'd100);
    tick();
    chk("c_climb1", 32'(addr), 32'd101);
    ticks(3);
    chk("c_climb4", 32'(addr), 32'd104);
    wait_state("c_hold2", ST_HOLD, 300);
    ptt_watch = 0;
    key_down = 1'b0;
    wait_state("c_idle", ST_IDLE, 300);
    // hang 3 ms: re-key inside hang, then expiry
    hang_time = 10'd3;
    key_down = 1'b1;
    wait_state("d_hold", ST_HOLD, 300);
    key_down = 1'b0;
    wait_addr("d_addr0", 10'd0, 300);
    ptt_watch = 1;
    tick();
    chk("d_hang", 32'(dut.r_state), 32'(ST_HANG));
    ticks(31);
    key_down = 1'b1;
    tick();
    chk("d_rekey", 32'(dut.r_state), 32'(ST_RAMP_UP));
    wait_state("d_hold2", ST_HOLD, 300);
    ptt_watch = 0;
    key_down = 1'b0;
    wait_addr("d_addr0b", 10'd0, 300);
    chk("d_rd_state", 32'(dut.r_state), 32'(ST_RAMP_DOWN));
    ticks(48);
    chk("d_hang_last", 32'(dut.r_state), 32'(ST_HANG));
    chk("d_hang_ptt", 32'(ptt), 32'd1);
    tick();
    chk("d_hang_idle", 32'(dut.r_state), 32'(ST_IDLE));
    chk("d_idle_ptt", 32'(ptt), 32'd0);
    // keyer_enable drop in HOLD and in DELAY_ON
    hang_time = 10'd0;
    delay_time = 8'd2;
    key_down = 1'b1;
    wait_state("e_hold", ST_HOLD, 400);
    keyer_enable = 1'b0;
    tick();
    chk("e_en_drop_rd", 32'(dut.r_state), 32'(ST_RAMP_DOWN));
    key_down = 1'b0;
    wait_state("e_idle", ST_IDLE, 300);
    chk("e_idle_addr", 32'(addr), 32'd0);
    keyer_enable = 1'b1;
    key_down = 1'b1;
    ticks(5);
    chk("e_delay_on", 32'(dut.r_state), 32'(ST_DELAY_ON));
    keyer_enable = 1'b0;
    tick();
    chk("e_abort_idle", 32'(dut.r_state), 32'(ST_IDLE));
    chk("e_abort_ptt", 32'(ptt), 32'd0);
    chk("e_abort_addr", 32'(addr), 32'd0);
    key_down = 1'b0;
    keyer_enable = 1'b1;
    tick();
    // asynchronous reset mid-ramp
    delay_time = 8'd0;
    key_down = 1'b1;
    wait_addr("f_addr120", 10'd120, 200);
    resetn = 1'b0;
    #1;
    chk("f_rst_ptt", 32'(ptt), 32'd0);
    chk("f_rst_addr", 32'(addr), 32'd0);
    chk("f_rst_tvalid", 32'(tvalid), 32'd0);
    chk("f_rst_bram_rst", 32'(brst), 32'd1);
    key_down = 1'b0;
    ticks(2);
    resetn = 1'b1;
    tick();
    chk("f_post_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("f_post_ptt", 32'(ptt), 32'd0);
    ticks(3);
    chk("f_post_addr", 32'(addr), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
